// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
package pipe_pkg;

  // Scoreboard entries store destinations at a fixed width wide enough for any supported register file.
  localparam int WA_W       = 8;
  localparam int FWD_SRC_RF = 0;

  typedef struct packed {
    logic            v;
    logic            we;
    logic [WA_W-1:0] wa;
    logic            late;
  } pipe_entry_t;

  function automatic int sel_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_fwd_match.sv
// Priority search of the scoreboard for one operand: youngest matching stage decides
// between a forwarding source and a hazard.
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 2,
  parameter int FWD_EN   = 1,
  parameter int REG_AW   = 3,
  localparam int SEL_W   = sel_w(STAGES)
) (
  input  logic                     issue_valid,
  input  logic                     uses,
  input  logic [REG_AW-1:0]        ra,
  input  pipe_entry_t [STAGES-1:0] sb,
  output logic                     hazard,
  output logic [SEL_W-1:0]         sel
);

  logic [WA_W-1:0] ra_ext;
  logic            hit;
  logic            hit_late;
  int              hit_k;

  assign ra_ext = WA_W'(ra);

  always_comb begin
    hit      = 1'b0;
    hit_late = 1'b0;
    hit_k    = 0;
    // Walk oldest to youngest so the lowest matching stage overrides.
    for (int k = STAGES; k >= 1; k--) begin
      if (issue_valid && uses && sb[k-1].v && sb[k-1].we && (sb[k-1].wa == ra_ext)) begin
        hit      = 1'b1;
        hit_k    = k;
        hit_late = sb[k-1].late;
      end
    end

    hazard = 1'b0;
    sel    = SEL_W'(FWD_SRC_RF);
    if (hit) begin
      if (FWD_EN != 0) begin
        if (hit_late && (hit_k < LOAD_LAT)) hazard = 1'b1;
        else                                sel    = SEL_W'(hit_k);
      end else begin
        // Without forwarding only the writeback stage can supply the value (write-through).
        if (hit_k < STAGES) hazard = 1'b1;
        else                sel    = SEL_W'(hit_k);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: shift-register scoreboard of in-flight writes,
// stall/flush issue control and saturating performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 2,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = sel_w(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_uses_a,
  input  logic [REG_AW-1:0] issue_ra,
  input  logic              issue_uses_b,
  input  logic [REG_AW-1:0] issue_rb,
  input  logic              issue_we,
  input  logic [REG_AW-1:0] issue_wa,
  input  logic              issue_late,
  input  logic              flush,
  output logic              issue_accept,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic [STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  if (STAGES < 2 || STAGES > 8 || LOAD_LAT < 1 || LOAD_LAT > STAGES || REG_AW > WA_W) begin : g_param_check
    $error("pipe_hazard_ctrl: illegal STAGES/LOAD_LAT/REG_AW combination");
  end

  pipe_entry_t [STAGES-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]         flush_cnt_q, flush_cnt_d;
  logic                     hazard_a, hazard_b;

  pipe_fwd_match #(
    .STAGES(STAGES), .LOAD_LAT(LOAD_LAT), .FWD_EN(FWD_EN), .REG_AW(REG_AW)
  ) u_match_a (
    .issue_valid(issue_valid), .uses(issue_uses_a), .ra(issue_ra),
    .sb(sb_q), .hazard(hazard_a), .sel(fwd_sel_a)
  );

  pipe_fwd_match #(
    .STAGES(STAGES), .LOAD_LAT(LOAD_LAT), .FWD_EN(FWD_EN), .REG_AW(REG_AW)
  ) u_match_b (
    .issue_valid(issue_valid), .uses(issue_uses_b), .ra(issue_rb),
    .sb(sb_q), .hazard(hazard_b), .sel(fwd_sel_b)
  );

  // Flush has priority: a squashed instruction never counts as stalled.
  assign stall        = issue_valid & (hazard_a | hazard_b) & ~flush;
  assign issue_accept = issue_valid & ~stall & ~flush;

  always_comb begin
    sb_d[0] = '0;
    if (issue_accept) begin
      sb_d[0].v    = 1'b1;
      sb_d[0].we   = issue_we;
      sb_d[0].wa   = WA_W'(issue_wa);
      sb_d[0].late = issue_late;
    end
    for (int k = 1; k < STAGES; k++) sb_d[k] = sb_q[k-1];

    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    stage_valid = '0;
    for (int k = 0; k < STAGES; k++) stage_valid[k] = sb_q[k].v;
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: a forwarding instance (3 stages, load latency 2) and a
// non-forwarding instance (4 stages, 2-bit counters) share one stimulus stream.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_uses_a, issue_uses_b, issue_we, issue_late, flush;
  logic [2:0] issue_ra, issue_rb, issue_wa;

  logic        acc0, stall0;
  logic [1:0]  sel_a0, sel_b0;
  logic [2:0]  sv0;
  logic [15:0] scnt0, fcnt0;

  logic        acc1, stall1;
  logic [2:0]  sel_a1, sel_b1;
  logic [3:0]  sv1;
  logic [1:0]  scnt1, fcnt1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(3), .STAGES(3), .LOAD_LAT(2), .FWD_EN(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_uses_a(issue_uses_a),
    .issue_ra(issue_ra), .issue_uses_b(issue_uses_b), .issue_rb(issue_rb),
    .issue_we(issue_we), .issue_wa(issue_wa), .issue_late(issue_late), .flush(flush),
    .issue_accept(acc0), .stall(stall0), .fwd_sel_a(sel_a0), .fwd_sel_b(sel_b0),
    .stage_valid(sv0), .stall_cnt(scnt0), .flush_cnt(fcnt0)
  );

  pipe_hazard_ctrl #(.REG_AW(3), .STAGES(4), .LOAD_LAT(4), .FWD_EN(0), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_uses_a(issue_uses_a),
    .issue_ra(issue_ra), .issue_uses_b(issue_uses_b), .issue_rb(issue_rb),
    .issue_we(issue_we), .issue_wa(issue_wa), .issue_late(issue_late), .flush(flush),
    .issue_accept(acc1), .stall(stall1), .fwd_sel_a(sel_a1), .fwd_sel_b(sel_b1),
    .stage_valid(sv1), .stall_cnt(scnt1), .flush_cnt(fcnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_uses_a = 0; issue_uses_b = 0; issue_we = 0;
    issue_late = 0; flush = 0; issue_ra = 0; issue_rb = 0; issue_wa = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic issue_write(input logic [2:0] wa, input logic late);
    idle();
    issue_valid = 1; issue_we = 1; issue_wa = wa; issue_late = late;
  endtask

  task automatic issue_read_a(input logic [2:0] ra);
    idle();
    issue_valid = 1; issue_uses_a = 1; issue_ra = ra;
  endtask

  task automatic test_reset();
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      issue_valid  = 1'($urandom);
      issue_uses_a = 1'($urandom);
      issue_uses_b = 1'($urandom);
      issue_we     = 1'($urandom);
      issue_late   = 1'($urandom);
      flush        = ($urandom_range(0, 3) == 0);
      issue_ra     = 3'($urandom);
      issue_rb     = 3'($urandom);
      issue_wa     = 3'($urandom);
      tick();
    end
    // Leave a write in flight so reset must discard it.
    issue_write(3'd3, 1'b0);
    tick();
    do_reset();
    tests++; if (sv0 !== 3'b000) begin fails++; $display("FAIL reset_sv0 got=%b exp=000", sv0); end
    tests++; if (sv1 !== 4'b0000) begin fails++; $display("FAIL reset_sv1 got=%b exp=0000", sv1); end
    tests++; if (scnt0 !== 16'd0 || fcnt0 !== 16'd0) begin fails++; $display("FAIL reset_cnt0 got=%0d/%0d exp=0/0", scnt0, fcnt0); end
    tests++; if (scnt1 !== 2'd0 || fcnt1 !== 2'd0) begin fails++; $display("FAIL reset_cnt1 got=%0d/%0d exp=0/0", scnt1, fcnt1); end
    issue_read_a(3'd3);
    #1;
    tests++; if (sel_a0 !== 2'd0 || stall0 !== 1'b0 || acc0 !== 1'b1) begin
      fails++; $display("FAIL reset_first_issue got sel=%0d stall=%b acc=%b exp 0/0/1", sel_a0, stall0, acc0);
    end
    tick();
    idle();
  endtask

  task automatic test_alu_fwd();
    do_reset();
    issue_write(3'd2, 1'b0);
    #1;
    tests++; if (acc0 !== 1'b1) begin fails++; $display("FAIL alu_writer_accept got=%b exp=1", acc0); end
    tick();
    issue_read_a(3'd2);
    #1;
    tests++; if (sel_a0 !== 2'd1 || stall0 !== 1'b0) begin
      fails++; $display("FAIL alu_fwd_stage1 got sel=%0d stall=%b exp 1/0", sel_a0, stall0);
    end
    tick();
    issue_read_a(3'd2);
    #1;
    tests++; if (sel_a0 !== 2'd2 || stall0 !== 1'b0) begin
      fails++; $display("FAIL alu_fwd_stage2 got sel=%0d stall=%b exp 2/0", sel_a0, stall0);
    end
    tick();
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    issue_write(3'd5, 1'b1);
    tick();
    issue_read_a(3'd5);
    #1;
    tests++; if (stall0 !== 1'b1 || acc0 !== 1'b0) begin
      fails++; $display("FAIL load_use_stall got stall=%b acc=%b exp 1/0", stall0, acc0);
    end
    tick();
    tests++; if (scnt0 !== 16'd1) begin fails++; $display("FAIL load_use_cnt got=%0d exp=1", scnt0); end
    tests++; if (stall0 !== 1'b0 || acc0 !== 1'b1 || sel_a0 !== 2'd2) begin
      fails++; $display("FAIL load_use_accept got stall=%b acc=%b sel=%0d exp 0/1/2", stall0, acc0, sel_a0);
    end
    tick();
    idle();
    #1;
    tests++; if (scnt0 !== 16'd1) begin fails++; $display("FAIL load_use_cnt_hold got=%0d exp=1", scnt0); end
  endtask

  task automatic test_youngest();
    do_reset();
    issue_write(3'd1, 1'b0);
    tick();
    idle();
    tick();
    issue_write(3'd1, 1'b0);
    tick();
    idle();
    issue_valid = 1; issue_uses_b = 1; issue_rb = 3'd1;
    #1;
    tests++; if (sv0 !== 3'b101) begin fails++; $display("FAIL youngest_sv got=%b exp=101", sv0); end
    tests++; if (sel_b0 !== 2'd1 || stall0 !== 1'b0) begin
      fails++; $display("FAIL youngest_sel_b got sel=%0d stall=%b exp 1/0", sel_b0, stall0);
    end
    tick();
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    issue_write(3'd4, 1'b1);
    tick();
    issue_read_a(3'd4);
    flush = 1;
    #1;
    tests++; if (stall0 !== 1'b0 || acc0 !== 1'b0) begin
      fails++; $display("FAIL flush_hazard got stall=%b acc=%b exp 0/0", stall0, acc0);
    end
    tick();
    idle();
    #1;
    tests++; if (fcnt0 !== 16'd1 || scnt0 !== 16'd0) begin
      fails++; $display("FAIL flush_cnt got flush=%0d stall=%0d exp 1/0", fcnt0, scnt0);
    end
    tests++; if (sv0 !== 3'b010) begin fails++; $display("FAIL flush_sv got=%b exp=010", sv0); end
  endtask

  task automatic test_fwd_off();
    do_reset();
    for (int round = 0; round < 2; round++) begin
      issue_write(3'd6, 1'b0);
      #1;
      tests++; if (acc1 !== 1'b1) begin fails++; $display("FAIL nofwd_writer_accept r%0d got=%b exp=1", round, acc1); end
      tick();
      issue_read_a(3'd6);
      for (int c = 0; c < 3; c++) begin
        #1;
        tests++; if (stall1 !== 1'b1 || acc1 !== 1'b0) begin
          fails++; $display("FAIL nofwd_stall r%0d c%0d got stall=%b acc=%b exp 1/0", round, c, stall1, acc1);
        end
        tick();
      end
      tests++; if (stall1 !== 1'b0 || acc1 !== 1'b1 || sel_a1 !== 3'd4) begin
        fails++; $display("FAIL nofwd_writethrough r%0d got stall=%b acc=%b sel=%0d exp 0/1/4", round, stall1, acc1, sel_a1);
      end
      tick();
    end
    idle();
    #1;
    tests++; if (scnt1 !== 2'd3) begin fails++; $display("FAIL nofwd_cnt_saturate got=%0d exp=3", scnt1); end
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_youngest();
    test_flush();
    test_fwd_off();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
